obstacle_spawn_scheduler: RTL and testbench
===========================================

# obstacle_spawn_scheduler

Sequences the 4-bit obstacle LFSR and turns its output into timed obstacle spawns. Steps the LFSR once per spawn, converts its value into a frame-count gap scaled by the current speed level, counts frame ticks down, then issues a held spawn request to the obstacle engine. Sits between the LFSR and the obstacle engine; the game controller drives `run`, `game_over` and `speed_lvl`.

## Interface
- `GAP_W`, 12: gap counter width; must be ≥ 12.
- `MIN_GAP`, 8: lower clamp on the scaled gap, in frame ticks; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: game running; 0 freezes countdown.
- `game_over` in 1: abort; returns the block to IDLE.
- `tick` in 1: one-cycle frame-tick strobe.
- `speed_lvl` in 2: gap right-shift amount, 0..3.
- `lfsr_val` in 4: LFSR bits q7..q4, with q7 as the MSB.
- `lfsr_step` out 1: one-cycle enable pulse to the LFSR.
- `spawn_req` out 1: spawn request, held until acknowledged.
- `spawn_ack` in 1: obstacle engine accepts the request.
- `spawn_kind` out 1: 0 = cactus, 1 = bird.
- `gap_cnt` out GAP_W: remaining ticks before the next request.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, LOAD, COUNT, REQ.
- All outputs decode from registered state and registers; there is no combinational input→output path.
- Reset (asynchronous): state = IDLE. All outputs read 0: `lfsr_step`, `spawn_req`, `spawn_kind`, `gap_cnt` and `busy`.
- IDLE: when `run`=1, go to LOAD.
- LOAD, exactly one cycle:
  - `lfsr_step`=1.
  - Capture `lfsr_val` (the pre-step value) into `gap_cnt = clamp(({4'b0, lfsr_val, 4'b1111}) >> speed_lvl)`, zero-extended to GAP_W. Clamp means values below MIN_GAP become MIN_GAP.
  - Capture `spawn_kind = lfsr_val[0]`.
  - Go to COUNT. A `tick` during LOAD is ignored.
- COUNT:
  - When `tick` and `run` are both 1, decrement `gap_cnt`.
  - If `gap_cnt`==1 on that tick, `gap_cnt` becomes 0 and the FSM goes to REQ.
  - `run`=0 freezes `gap_cnt` and holds the state.
- REQ:
  - `spawn_req`=1.
  - On `spawn_ack`=1, go to LOAD.
  - `run`=0 does not drop `spawn_req`. `tick` is ignored.
- `game_over`=1 in any state: next state IDLE, `spawn_req`=0, `gap_cnt`=0.
- Priority: `reset` > `game_over` > `spawn_ack` > `tick`.
- `speed_lvl` is sampled only in LOAD. Changes during COUNT affect the next gap only.
- Unscaled gap range is 15..255. At `speed_lvl`=3 the raw range is 1..31, clamped to MIN_GAP..31.

## Timing
- `run` sampled high at edge E0: LOAD is active in cycle E0..E1, with `lfsr_step` high during that cycle. `gap_cnt` is valid and the FSM is in COUNT after E1.
- `spawn_req` rises in the cycle after the edge that samples the G-th qualifying tick, where G is the loaded gap.
- `spawn_ack` sampled at edge Ea: `spawn_req` falls after Ea, and LOAD (a new `lfsr_step` pulse) occupies the next cycle.
- Minimum request-to-request spacing: 2 cycles plus MIN_GAP ticks.
- `spawn_ack` while `spawn_req`=0 is ignored.
- `lfsr_step` never stays high for more than one consecutive cycle.

## Configuration
- `OBSTACLE_SPAWN_STATS_EN` defined: adds output `spawn_count` [15:0].
  - Increments on each accepted spawn (REQ with `spawn_ack`=1).
  - Saturates at 16'hFFFF.
  - Cleared by `reset` only; `game_over` does not clear it.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared header `spawn_sched_defs.vh`: state encodings (IDLE=2'd0, LOAD=2'd1, COUNT=2'd2, REQ=2'd3), the default MIN_GAP, and the pad constants (high pad 4'b0000, low pad 4'b1111).
- One sub-module, `spawn_gap_calc`: purely combinational. Computes pad, shift and clamp from `lfsr_val`, `speed_lvl` and MIN_GAP.
- The LFSR itself stays external and is driven only through `lfsr_step`.

## Test plan
- Reset mid-COUNT with `gap_cnt`=40: outputs go to 0 immediately (asynchronous). After release, IDLE is held while `run`=0.
- `lfsr_val`=4'hA, `speed_lvl`=0, `run`=1: one `lfsr_step` pulse, `gap_cnt`=175, `spawn_kind`=0. `spawn_req` rises after exactly 175 ticks.
- `lfsr_val`=4'h0, `speed_lvl`=3: raw gap 1, clamped `gap_cnt`=8. `spawn_req` after 8 ticks.
- `spawn_req` held for 5 cycles with `spawn_ack`=0 and `run` toggled: request stays high. Ack in cycle 6: request drops and one `lfsr_step` pulse follows.
- `game_over` asserted in the same cycle as `spawn_ack` while in REQ: next state IDLE, with no `lfsr_step` and (with `OBSTACLE_SPAWN_STATS_EN`) no `spawn_count` increment.
- `run`=0 for 10 ticks in COUNT at `gap_cnt`=20: `gap_cnt` stays 20. After `run` returns to 1, the request comes after 20 more ticks.

Source files
------------

// File: rtl/obstacle_spawn_scheduler_pkg.sv
// Shared definitions for the obstacle spawn scheduler: FSM state
// encodings, default minimum gap and the pad constants used to widen
// the 4-bit LFSR value into a frame-count gap.
package obstacle_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_REQ   = 2'd3
    } state_t;

    localparam int DEFAULT_MIN_GAP = 8;

    // Padded gap is {PAD_HI, lfsr_val, PAD_LO}: 15..255 unscaled.
    localparam logic [3:0] PAD_HI = 4'b0000;
    localparam logic [3:0] PAD_LO = 4'b1111;
    localparam int         RAW_W  = 12;

endpackage

// File: rtl/spawn_gap_calc.sv
// spawn_gap_calc: purely combinational gap computation. Pads the LFSR
// value, right-shifts it by the speed level and clamps the result to
// MIN_GAP, zero-extended to GAP_W.
module spawn_gap_calc
    import obstacle_spawn_scheduler_pkg::*;
#(
    parameter int GAP_W   = 12,
    parameter int MIN_GAP = DEFAULT_MIN_GAP
) (
    input  logic [3:0]       lfsr_val,
    input  logic [1:0]       speed_lvl,
    output logic [GAP_W-1:0] gap
);

    localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

    logic [RAW_W-1:0] padded;
    logic [RAW_W-1:0] shifted;
    logic [GAP_W-1:0] gap_ext;

    // Pad, shift by speed level, then clamp the short gaps up to MIN_GAP.
    always_comb begin
        padded  = {PAD_HI, lfsr_val, PAD_LO};
        shifted = padded >> speed_lvl;
        gap_ext = GAP_W'(shifted);
        gap     = (gap_ext < MIN_GAP_V) ? MIN_GAP_V : gap_ext;
    end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler: steps the external obstacle LFSR once per
// spawn, turns its value into a tick-count gap and issues a held spawn
// request once the gap has elapsed.
// Optional feature macro: OBSTACLE_SPAWN_STATS_EN adds a saturating
// 16-bit spawn_count of accepted spawns (cleared by reset only).
//
// Handshake: spawn_req is the valid, spawn_ack the ready. A spawn is
// accepted at a clock edge where spawn_req=1 and spawn_ack=1; spawn_req
// stays high (regardless of run/tick) until then, and spawn_ack with
// spawn_req=0 has no effect. game_over overrides an accept in the same
// cycle.
module obstacle_spawn_scheduler
    import obstacle_spawn_scheduler_pkg::*;
#(
    parameter int GAP_W   = 12,
    parameter int MIN_GAP = DEFAULT_MIN_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             game_over,
    input  logic             tick,
    input  logic [1:0]       speed_lvl,
    input  logic [3:0]       lfsr_val,
    output logic             lfsr_step,
    output logic             spawn_req,
    input  logic             spawn_ack,
    output logic             spawn_kind,
    output logic [GAP_W-1:0] gap_cnt,
    output logic             busy,
`ifdef OBSTACLE_SPAWN_STATS_EN
    output logic [15:0]      spawn_count,
`endif
    output logic [1:0]       state_dbg
);

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_nxt;
    logic             kind_nxt;
    logic [GAP_W-1:0] new_gap;
    logic             accept;

    spawn_gap_calc #(
        .GAP_W   (GAP_W),
        .MIN_GAP (MIN_GAP)
    ) u_gap_calc (
        .lfsr_val  (lfsr_val),
        .speed_lvl (speed_lvl),
        .gap       (new_gap)
    );

    // Outputs decode from registered state only.
    assign lfsr_step = (state == ST_LOAD);
    assign spawn_req = (state == ST_REQ);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
    assign accept    = (state == ST_REQ) && spawn_ack && !game_over;

    // Next-state and next-register logic; game_over beats ack beats tick.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        kind_nxt  = spawn_kind;
        if (game_over) begin
            state_nxt = ST_IDLE;
            gap_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    gap_nxt   = new_gap;
                    kind_nxt  = lfsr_val[0];
                    state_nxt = ST_COUNT;
                end
                ST_COUNT: begin
                    if (tick && run) begin
                        gap_nxt = gap_cnt - 1'b1;
                        if (gap_cnt == GAP_W'(1)) state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (spawn_ack) state_nxt = ST_LOAD;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            spawn_kind <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            spawn_kind <= kind_nxt;
        end
    end

`ifdef OBSTACLE_SPAWN_STATS_EN
    // Saturating count of accepted spawns; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spawn_count <= '0;
        end else if (accept && (spawn_count != 16'hFFFF)) begin
            spawn_count <= spawn_count + 16'd1;
        end
    end
`else
    // Without statistics the accept strobe has no consumer.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: directed scenarios plus a
// randomized run against a behavioural gap/timing model.
module tb_obstacle_spawn_scheduler;

    localparam int GAP_W   = 12;
    localparam int MIN_GAP = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic             game_over;
    logic             tick;
    logic [1:0]       speed_lvl;
    logic [3:0]       lfsr_val;
    logic             lfsr_step;
    logic             spawn_req;
    logic             spawn_ack;
    logic             spawn_kind;
    logic [GAP_W-1:0] gap_cnt;
    logic             busy;
    logic [1:0]       state_dbg;
`ifdef OBSTACLE_SPAWN_STATS_EN
    logic [15:0]      spawn_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_spawns = 0;
    logic [GAP_W-1:0] exp_q[$];

    obstacle_spawn_scheduler #(
        .GAP_W   (GAP_W),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .game_over  (game_over),
        .tick       (tick),
        .speed_lvl  (speed_lvl),
        .lfsr_val   (lfsr_val),
        .lfsr_step  (lfsr_step),
        .spawn_req  (spawn_req),
        .spawn_ack  (spawn_ack),
        .spawn_kind (spawn_kind),
        .gap_cnt    (gap_cnt),
        .busy       (busy),
`ifdef OBSTACLE_SPAWN_STATS_EN
        .spawn_count(spawn_count),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference gap: pad with four ones below, scale down, clamp.
    function automatic int ref_gap(input int v, input int s);
        int raw;
        raw = (v * 16 + 15) / (1 << s);
        if (raw < MIN_GAP) raw = MIN_GAP;
        return raw;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; game_over = 1'b0; tick = 1'b0;
        speed_lvl = 2'd0; lfsr_val = 4'd0; spawn_ack = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        exp_spawns = 0;
    endtask

    // From IDLE: pass through LOAD with the given LFSR value and speed.
    task automatic start_spawn(input logic [3:0] v, input logic [1:0] s);
        run = 1'b1; lfsr_val = v; speed_lvl = s;
        cyc();
        cyc();
    endtask

    // Drive n qualifying ticks.
    task automatic tick_n(input int n);
        tick = 1'b1; run = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if ({busy, lfsr_step, spawn_req, spawn_kind, gap_cnt, state_dbg} !== '0)
                $display("FAIL reset_idle: busy=%0b step=%0b req=%0b kind=%0b gap=%0d st=%0d, expected all 0",
                         busy, lfsr_step, spawn_req, spawn_kind, gap_cnt, state_dbg);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        start_spawn(4'hA, 2'd0);
        tick_n(135);
        n_checks++;
        if (gap_cnt !== 12'd40) $display("FAIL midcount_gap: got %0d, expected 40", gap_cnt);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, lfsr_step, spawn_req, spawn_kind, gap_cnt} !== '0)
            $display("FAIL async_reset: busy=%0b step=%0b req=%0b kind=%0b gap=%0d, expected all 0",
                     busy, lfsr_step, spawn_req, spawn_kind, gap_cnt);
        else n_pass++;
        cyc();
        reset = 1'b0; run = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        n_checks++;
        if (busy !== 1'b0 || lfsr_step !== 1'b0)
            $display("FAIL idle_hold: busy=%0b step=%0b, expected 0 0", busy, lfsr_step);
        else n_pass++;
    endtask

    task automatic test_basic_gap();
        do_reset();
        run = 1'b1; lfsr_val = 4'hA; speed_lvl = 2'd0;
        cyc();
        n_checks++;
        if (lfsr_step !== 1'b1 || busy !== 1'b1)
            $display("FAIL basic_load: step=%0b busy=%0b, expected 1 1", lfsr_step, busy);
        else n_pass++;
        cyc();
        n_checks++;
        if (gap_cnt !== 12'd175 || spawn_kind !== 1'b0 || lfsr_step !== 1'b0)
            $display("FAIL basic_gap: gap=%0d kind=%0b step=%0b, expected 175 0 0",
                     gap_cnt, spawn_kind, lfsr_step);
        else n_pass++;
        tick_n(174);
        n_checks++;
        if (spawn_req !== 1'b0 || gap_cnt !== 12'd1)
            $display("FAIL basic_early: req=%0b gap=%0d, expected 0 1", spawn_req, gap_cnt);
        else n_pass++;
        tick_n(1);
        n_checks++;
        if (spawn_req !== 1'b1 || gap_cnt !== 12'd0)
            $display("FAIL basic_req: req=%0b gap=%0d, expected 1 0", spawn_req, gap_cnt);
        else n_pass++;
    endtask

    task automatic test_clamp();
        do_reset();
        run = 1'b1; lfsr_val = 4'h0; speed_lvl = 2'd3;
        cyc();
        tick = 1'b1;  // tick during LOAD must be ignored
        cyc();
        tick = 1'b0;
        n_checks++;
        if (gap_cnt !== 12'd8 || spawn_kind !== 1'b0)
            $display("FAIL clamp_gap: gap=%0d kind=%0b, expected 8 0", gap_cnt, spawn_kind);
        else n_pass++;
        tick_n(7);
        n_checks++;
        if (spawn_req !== 1'b0) $display("FAIL clamp_early: req=%0b, expected 0", spawn_req);
        else n_pass++;
        tick_n(1);
        n_checks++;
        if (spawn_req !== 1'b1) $display("FAIL clamp_req: req=%0b, expected 1", spawn_req);
        else n_pass++;
    endtask

    task automatic test_req_hold();
        do_reset();
        start_spawn(4'h0, 2'd3);
        tick_n(8);
        for (int i = 0; i < 5; i++) begin
            run = i[0]; tick = 1'b1;
            cyc();
            n_checks++;
            if (spawn_req !== 1'b1 || gap_cnt !== 12'd0)
                $display("FAIL hold_req[%0d]: req=%0b gap=%0d, expected 1 0", i, spawn_req, gap_cnt);
            else n_pass++;
        end
        tick = 1'b0; run = 1'b1;
        spawn_ack = 1'b1; lfsr_val = 4'h3; speed_lvl = 2'd1;
        cyc();
        spawn_ack = 1'b0;
        exp_spawns++;
        n_checks++;
        if (spawn_req !== 1'b0 || lfsr_step !== 1'b1)
            $display("FAIL hold_ack: req=%0b step=%0b, expected 0 1", spawn_req, lfsr_step);
        else n_pass++;
        cyc();
        n_checks++;
        if (lfsr_step !== 1'b0 || spawn_kind !== 1'b1 || gap_cnt !== GAP_W'(ref_gap(3, 1)))
            $display("FAIL hold_reload: step=%0b kind=%0b gap=%0d, expected 0 1 %0d",
                     lfsr_step, spawn_kind, gap_cnt, ref_gap(3, 1));
        else n_pass++;
`ifdef OBSTACLE_SPAWN_STATS_EN
        n_checks++;
        if (spawn_count !== 16'(exp_spawns))
            $display("FAIL hold_count: got %0d, expected %0d", spawn_count, exp_spawns);
        else n_pass++;
`endif
    endtask

    task automatic test_gameover_ack();
        do_reset();
        start_spawn(4'h0, 2'd3);
        tick_n(8);
        game_over = 1'b1; spawn_ack = 1'b1; run = 1'b0;
        cyc();
        n_checks++;
        if ({busy, lfsr_step, spawn_req, gap_cnt, state_dbg} !== '0)
            $display("FAIL gameover_ack: busy=%0b step=%0b req=%0b gap=%0d st=%0d, expected all 0",
                     busy, lfsr_step, spawn_req, gap_cnt, state_dbg);
        else n_pass++;
        game_over = 1'b0; spawn_ack = 1'b0;
        cyc();
        n_checks++;
        if (lfsr_step !== 1'b0 || busy !== 1'b0)
            $display("FAIL gameover_idle: step=%0b busy=%0b, expected 0 0", lfsr_step, busy);
        else n_pass++;
`ifdef OBSTACLE_SPAWN_STATS_EN
        n_checks++;
        if (spawn_count !== 16'(exp_spawns))
            $display("FAIL gameover_count: got %0d, expected %0d", spawn_count, exp_spawns);
        else n_pass++;
`endif
    endtask

    task automatic test_freeze();
        do_reset();
        start_spawn(4'hA, 2'd0);
        tick_n(155);
        run = 1'b0; tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        n_checks++;
        if (gap_cnt !== 12'd20 || state_dbg !== 2'd2)
            $display("FAIL freeze_gap: gap=%0d st=%0d, expected 20 2", gap_cnt, state_dbg);
        else n_pass++;
        tick_n(19);
        n_checks++;
        if (spawn_req !== 1'b0) $display("FAIL freeze_early: req=%0b, expected 0", spawn_req);
        else n_pass++;
        tick_n(1);
        n_checks++;
        if (spawn_req !== 1'b1) $display("FAIL freeze_req: req=%0b, expected 1", spawn_req);
        else n_pass++;
    endtask

    // Random gaps, random tick/run patterns and ack delays against the model.
    task automatic test_random_spawns();
        int v, s, rem, guard, exp_kind;
        do_reset();
        v = $urandom_range(0, 15); s = $urandom_range(0, 3);
        run = 1'b1; lfsr_val = 4'(v); speed_lvl = 2'(s);
        cyc();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(GAP_W'(ref_gap(v, s)));
            exp_kind = v % 2;
            n_checks++;
            if (lfsr_step !== 1'b1 || spawn_req !== 1'b0)
                $display("FAIL rnd_load[%0d]: step=%0b req=%0b, expected 1 0", k, lfsr_step, spawn_req);
            else n_pass++;
            tick = 1'($urandom_range(0, 1));
            cyc();
            rem = int'(exp_q.pop_front());
            n_checks++;
            if (gap_cnt !== GAP_W'(rem) || spawn_kind !== 1'(exp_kind) || lfsr_step !== 1'b0)
                $display("FAIL rnd_gap[%0d]: gap=%0d kind=%0b step=%0b, expected %0d %0d 0",
                         k, gap_cnt, spawn_kind, lfsr_step, rem, exp_kind);
            else n_pass++;
            guard = 0;
            while (rem > 0 && guard < 4000) begin
                tick = 1'($urandom_range(0, 1));
                run = ($urandom_range(0, 7) != 0);
                speed_lvl = 2'($urandom_range(0, 3));
                cyc();
                guard++;
                if (tick && run) rem--;
                n_checks++;
                if (gap_cnt !== GAP_W'(rem) || spawn_req !== (rem == 0) || lfsr_step !== 1'b0)
                    $display("FAIL rnd_count[%0d]: gap=%0d req=%0b step=%0b, expected %0d %0b 0",
                             k, gap_cnt, spawn_req, lfsr_step, rem, rem == 0);
                else n_pass++;
            end
            n_checks++;
            if (rem != 0) $display("FAIL rnd_timeout[%0d]: remaining=%0d, expected 0", k, rem);
            else n_pass++;
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                tick = 1'($urandom_range(0, 1));
                run = 1'($urandom_range(0, 1));
                cyc();
                n_checks++;
                if (spawn_req !== 1'b1) $display("FAIL rnd_hold[%0d]: req=%0b, expected 1", k, spawn_req);
                else n_pass++;
            end
            v = $urandom_range(0, 15); s = $urandom_range(0, 3);
            lfsr_val = 4'(v); speed_lvl = 2'(s); spawn_ack = 1'b1; tick = 1'b0;
            cyc();
            spawn_ack = 1'b0;
            exp_spawns++;
        end
`ifdef OBSTACLE_SPAWN_STATS_EN
        n_checks++;
        if (spawn_count !== 16'(exp_spawns))
            $display("FAIL rnd_count_total: got %0d, expected %0d", spawn_count, exp_spawns);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_basic_gap();
        test_clamp();
        test_req_hold();
        test_gameover_ack();
        test_freeze();
        test_random_spawns();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
